// File: rtl/ll_pkg.sv
// Shared constants for the LL decimator slice.
//   PIX_W       : pixel width on the actor streams
//   PAIR_W      : horizontal pair sum width (no truncation)
//   QUAD_W      : 2x2 block sum width
//   TOKEN_COUNT : constant COUNT value advertised on output ports
//   ROUND_BIAS  : added before the divide-by-4 so halves round up
package ll_pkg;

  localparam int          PIX_W       = 16;
  localparam int          PAIR_W      = 17;
  localparam int          QUAD_W      = 18;
  localparam logic [15:0] TOKEN_COUNT = 16'h1;
  localparam int          ROUND_BIAS  = 2;

  // Rounded mean of a 2x2 block sum. Max sum 4*65535 plus the bias still
  // fits QUAD_W, and the result fits PIX_W, so no saturation is required.
  function automatic logic [PIX_W-1:0] round_avg4(input logic [QUAD_W-1:0] total);
    logic [QUAD_W-1:0] biased;
    biased = total + QUAD_W'(ROUND_BIAS);
    return biased[QUAD_W-1:2];
  endfunction

endpackage

// File: rtl/ll_linebuf.sv
// Half-line buffer: simple dual-port RAM holding even-row pair sums.
//   CLK      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data (pair sum)
//   i_re     : read enable; o_rdata updates only when set, so the last
//              read value stays valid across input gaps
//   i_raddr  : read address
//   o_rdata  : registered read data (1-cycle latency)
// No reset: every entry is written on an even row before it is read.
module ll_linebuf
  import ll_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [PAIR_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [PAIR_W-1:0] o_rdata
);

  logic [PAIR_W-1:0] r_mem [DEPTH];
  logic [PAIR_W-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge CLK) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ll_downsample2x2.sv
// Streaming 2x2 box-filter decimator producing the next-coarser LL subband.
// Consumes a raster-order pixel stream and emits one rounded 2x2 mean per
// block (quarter-size frame) on the SEND/ACK/RDY/COUNT actor protocol.
//   CLK, RESET  : clock, asynchronous active-high reset
//   In1_DATA    : input pixel
//   In1_SEND    : upstream token valid
//   In1_COUNT   : upstream count (unused, tokens taken one at a time)
//   In1_ACK     : token consumed this cycle
//   Out1_DATA   : averaged pixel
//   Out1_SEND   : output token strobe
//   Out1_COUNT  : constant 1
//   Out1_RDY    : downstream can take a token this cycle
//   Out1_ACK    : downstream acknowledge (unused)
module ll_downsample2x2
  import ll_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [PIX_W-1:0] In1_DATA,
  input  logic             In1_SEND,
  input  logic [15:0]      In1_COUNT,
  output logic             In1_ACK,
  output logic [PIX_W-1:0] Out1_DATA,
  output logic             Out1_SEND,
  output logic [15:0]      Out1_COUNT,
  input  logic             Out1_RDY,
  input  logic             Out1_ACK
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [PIX_W-1:0]  r_hold;
  logic [PIX_W-1:0]  r_obuf;
  logic              r_pend;

  logic              w_ack;
  logic              w_even_col;
  logic              w_odd_row;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_lb_we;
  logic              w_lb_re;
  logic              w_emit;
  logic [AW-1:0]     w_lb_addr;
  logic [PAIR_W-1:0] w_pair;
  logic [PAIR_W-1:0] w_lb_rdata;
  logic [QUAD_W-1:0] w_total;
  logic              w_unused;

  assign w_unused = ^{In1_COUNT, Out1_ACK};

  // Single-entry output: input is frozen while a result is waiting, which
  // guarantees a block never completes on top of an unsent one.
  assign w_ack      = In1_SEND & ~r_pend;
  assign w_even_col = ~r_col[0];
  assign w_odd_row  = r_row[0];
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_lb_addr  = AW'(r_col >> 1);

  // Even row, odd column stores the pair sum; odd row, even column fetches
  // it so it is ready by the time the odd-column partner pixel arrives.
  assign w_lb_we = w_ack & ~w_even_col & ~w_odd_row;
  assign w_lb_re = w_ack &  w_even_col &  w_odd_row;
  assign w_emit  = w_ack & ~w_even_col &  w_odd_row;

  assign w_pair  = PAIR_W'(r_hold) + PAIR_W'(In1_DATA);
  assign w_total = QUAD_W'(w_lb_rdata) + QUAD_W'(r_hold) + QUAD_W'(In1_DATA);

  ll_linebuf #(
    .DEPTH (LB_DEPTH),
    .AW    (AW)
  ) u_linebuf (
    .CLK     (CLK),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_pair),
    .i_re    (w_lb_re),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  // Raster position and first-of-pair holding register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hold <= '0;
    end else if (w_ack) begin
      if (w_even_col) r_hold <= In1_DATA;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Output register. Reset drops any pending result so the new frame
  // starts clean.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_obuf <= '0;
      r_pend <= 1'b0;
    end else if (w_emit) begin
      r_obuf <= round_avg4(w_total);
      r_pend <= 1'b1;
    end else if (Out1_SEND) begin
      r_pend <= 1'b0;
    end
  end

  assign In1_ACK    = w_ack;
  assign Out1_SEND  = r_pend & Out1_RDY;
  assign Out1_DATA  = r_obuf;
  assign Out1_COUNT = TOKEN_COUNT;

endmodule

// File: tb/tb_ll_downsample2x2.sv
// Directed bench for ll_downsample2x2 using three instances:
//   d=0 : 4x2 frames (table vectors, back-to-back frames, backpressure)
//   d=1 : 8x4 frame with random input gaps
//   d=2 : 4x4 frame with mid-frame reset
module tb_ll_downsample2x2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] in_data  [3];
  logic        in_send  [3];
  logic        in_ack   [3];
  logic [15:0] out_data [3];
  logic        out_send [3];
  logic [15:0] out_count[3];
  logic        rdy      [3];
  logic [15:0] in_count = 16'h1;
  logic        out_ack  = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 CLK = ~CLK;

  ll_downsample2x2 #(.IMG_W(4), .IMG_H(2)) u_d0 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(in_data[0]), .In1_SEND(in_send[0]),
    .In1_COUNT(in_count), .In1_ACK(in_ack[0]), .Out1_DATA(out_data[0]),
    .Out1_SEND(out_send[0]), .Out1_COUNT(out_count[0]), .Out1_RDY(rdy[0]),
    .Out1_ACK(out_ack));

  ll_downsample2x2 #(.IMG_W(8), .IMG_H(4)) u_d1 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(in_data[1]), .In1_SEND(in_send[1]),
    .In1_COUNT(in_count), .In1_ACK(in_ack[1]), .Out1_DATA(out_data[1]),
    .Out1_SEND(out_send[1]), .Out1_COUNT(out_count[1]), .Out1_RDY(rdy[1]),
    .Out1_ACK(out_ack));

  ll_downsample2x2 #(.IMG_W(4), .IMG_H(4)) u_d2 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(in_data[2]), .In1_SEND(in_send[2]),
    .In1_COUNT(in_count), .In1_ACK(in_ack[2]), .Out1_DATA(out_data[2]),
    .Out1_SEND(out_send[2]), .Out1_COUNT(out_count[2]), .Out1_RDY(rdy[2]),
    .Out1_ACK(out_ack));

  // Output capture, sampled away from the active edge.
  always @(negedge CLK) begin
    if (out_send[0]) q0.push_back(out_data[0]);
    if (out_send[1]) q1.push_back(out_data[1]);
    if (out_send[2]) q2.push_back(out_data[2]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one pixel and hold it until consumed; bounded wait.
  task automatic send_pix(input int k, input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    in_data[k] = v;
    in_send[k] = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge CLK);
      if (in_ack[k]) ok = 1'b1;
    end
    @(posedge CLK); #1;
    in_send[k] = 1'b0;
    chk("ack_within_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  typedef struct {
    logic [15:0] px [8];
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tbl [5];
  logic [15:0] img8 [32];
  logic [15:0] exp8 [8];
  logic [15:0] img4 [16];
  logic [15:0] exp4 [4];
  logic [15:0] v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 4x2 frames: row0 = px[0..3], row1 = px[4..7]
    tbl[0].px = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].e0 = 16'd4;     tbl[0].e1 = 16'd6;
    tbl[1].px = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd1};
    tbl[1].e0 = 16'd1;     tbl[1].e1 = 16'd0;
    tbl[2].px = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[2].e0 = 16'hFFFF;  tbl[2].e1 = 16'hFFFF;
    tbl[3].px = '{16'd100, 16'd200, 16'd7, 16'd9, 16'd300, 16'd401, 16'd10, 16'd11};
    tbl[3].e0 = 16'd250;   tbl[3].e1 = 16'd9;
    tbl[4].px = '{16'd3, 16'd0, 16'd65535, 16'd0, 16'd0, 16'd0, 16'd0, 16'd65534};
    tbl[4].e0 = 16'd1;     tbl[4].e1 = 16'd32767;

    img4 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80,
             16'd1,  16'd2,  16'd3,  16'd4,  16'd5,  16'd6,  16'd7,  16'd9};
    exp4 = '{16'd35, 16'd55, 16'd4, 16'd6};

    for (int k = 0; k < 3; k++) begin
      in_data[k] = '0; in_send[k] = 1'b0; rdy[k] = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_send", {31'd0, out_send[k]}, 32'd0);
      chk("rst_out_data", {16'd0, out_data[k]}, 32'd0);
      chk("rst_out_count", {16'd0, out_count[k]}, 32'd1);
      chk("rst_in_ack", {31'd0, in_ack[k]}, 32'd0);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(1);

    // Table vectors, back-to-back 4x2 frames, with 1-cycle latency checks
    for (int i = 0; i < 5; i++) begin
      q0.delete();
      for (int p = 0; p < 8; p++) begin
        send_pix(0, tbl[i].px[p]);
        if (p == 5 || p == 7) begin
          @(negedge CLK);
          chk("latency_send", {31'd0, out_send[0]}, 32'd1);
          chk("out_count", {16'd0, out_count[0]}, 32'd1);
        end
      end
      idle(3);
      chk("vec_ntok", q0.size(), 32'd2);
      v = (q0.size() > 0) ? q0.pop_front() : 16'hDEAD;
      chk("vec_out0", {16'd0, v}, {16'd0, tbl[i].e0});
      v = (q0.size() > 0) ? q0.pop_front() : 16'hDEAD;
      chk("vec_out1", {16'd0, v}, {16'd0, tbl[i].e1});
    end

    // Backpressure: RDY low for 10 cycles with the first result pending
    q0.delete();
    rdy[0] = 1'b0;
    for (int p = 0; p < 6; p++) send_pix(0, tbl[0].px[p]);
    in_data[0] = tbl[0].px[6];
    in_send[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("bp_send_low", {31'd0, out_send[0]}, 32'd0);
      chk("bp_ack_low", {31'd0, in_ack[0]}, 32'd0);
      chk("bp_data_stable", {16'd0, out_data[0]}, 32'd4);
    end
    @(posedge CLK); #1;
    rdy[0] = 1'b1;
    @(negedge CLK);
    chk("bp_send_on_rdy", {31'd0, out_send[0]}, 32'd1);
    chk("bp_data_on_rdy", {16'd0, out_data[0]}, 32'd4);
    chk("bp_ack_still_low", {31'd0, in_ack[0]}, 32'd0);
    in_send[0] = 1'b0;
    send_pix(0, tbl[0].px[6]);
    send_pix(0, tbl[0].px[7]);
    idle(3);
    chk("bp_ntok", q0.size(), 32'd2);
    v = (q0.size() > 0) ? q0.pop_front() : 16'hDEAD;
    chk("bp_out0", {16'd0, v}, 32'd4);
    v = (q0.size() > 0) ? q0.pop_front() : 16'hDEAD;
    chk("bp_out1", {16'd0, v}, 32'd6);

    // 8x4 frame with random SEND gaps against a block-average model
    for (int i = 0; i < 32; i++) img8[i] = 16'($urandom_range(0, 65535));
    for (int br = 0; br < 2; br++)
      for (int bc = 0; bc < 4; bc++) begin
        int s;
        s = int'(img8[(2*br)*8 + 2*bc]) + int'(img8[(2*br)*8 + 2*bc + 1])
          + int'(img8[(2*br+1)*8 + 2*bc]) + int'(img8[(2*br+1)*8 + 2*bc + 1]);
        exp8[br*4 + bc] = 16'((s + 2) / 4);
      end
    q1.delete();
    for (int i = 0; i < 32; i++) begin
      idle($urandom_range(0, 3));
      send_pix(1, img8[i]);
    end
    idle(4);
    chk("gap_ntok", q1.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      v = (q1.size() > 0) ? q1.pop_front() : 16'hDEAD;
      chk("gap_out", {16'd0, v}, {16'd0, exp8[i]});
    end

    // Mid-frame reset on 4x4 with a result pending
    rdy[2] = 1'b0;
    for (int p = 0; p < 6; p++) send_pix(2, 16'(900 + p));
    in_data[2] = 16'd906;
    in_send[2] = 1'b1;
    @(negedge CLK);
    chk("rstmid_ack_blocked", {31'd0, in_ack[2]}, 32'd0);
    #2;
    RESET = 1'b1;
    #1;
    chk("rstmid_async_clear", {31'd0, in_ack[2]}, 32'd1);
    in_send[2] = 1'b0;
    rdy[2] = 1'b1;
    q2.delete();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(3);
    chk("rstmid_no_stale", q2.size(), 32'd0);
    for (int p = 0; p < 16; p++) send_pix(2, img4[p]);
    idle(3);
    chk("rstmid_ntok", q2.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      v = (q2.size() > 0) ? q2.pop_front() : 16'hDEAD;
      chk("rstmid_out", {16'd0, v}, {16'd0, exp4[i]});
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
